// File: rtl/clock_time_counter_pkg.sv
// clock_pkg: shared BCD field type, field limits, set-select encodings and BCD step helper.
package clock_pkg;
  typedef logic [7:0] bcd_t;
  typedef enum logic [1:0] {SEL_SEC = 2'b00, SEL_MIN = 2'b01, SEL_HOUR = 2'b10, SEL_NONE = 2'b11} sel_e;
  localparam bcd_t BCD_59 = 8'h59;
  localparam bcd_t BCD_23 = 8'h23;
  function automatic bcd_t bcd_next(bcd_t v, bcd_t max);
    return (v == max) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
endpackage

// File: rtl/clock_time_counter_if.sv
// clock_time_counter_if: control inputs and time/pulse outputs of the time-of-day counter.
interface clock_time_counter_if;
  import clock_pkg::*;
  logic tick_1hz;
  logic set_mode;
  logic [1:0] set_sel;
  logic set_inc;
  bcd_t hour;
  bcd_t min;
  bcd_t sec;
  logic chime;
  logic day_carry;
  modport master (output tick_1hz, set_mode, set_sel, set_inc, input hour, min, sec, chime, day_carry);
  modport slave (input tick_1hz, set_mode, set_sel, set_inc, output hour, min, sec, chime, day_carry);
endinterface

// File: rtl/clock_time_counter_bcd.sv
// bcd_field_counter: one wrapping BCD time field; carry_out flags a wrap only when carry_in_en allows chaining.
module bcd_field_counter
  import clock_pkg::*;
#(
  parameter bcd_t MAX_BCD   = BCD_59,
  parameter bcd_t RESET_VAL = 8'h00
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic carry_in_en,
  output bcd_t value,
  output logic carry_out
);
  bcd_t value_q, value_d;
  always_comb value_d = inc ? bcd_next(value_q, MAX_BCD) : value_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value_q <= RESET_VAL;
    else value_q <= value_d;
  assign value = value_q;
  assign carry_out = inc && carry_in_en && (value_q == MAX_BCD);
endmodule

// File: rtl/clock_time_counter.sv
// clock_time_counter: BCD hh:mm:ss counter with 1 Hz advance, manual field setting,
// and registered hourly-chime / day-rollover pulses.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter bcd_t RESET_HOUR = 8'h00,
  parameter bcd_t RESET_MIN  = 8'h00
) (
  input logic clk,
  input logic rst_n,
  clock_time_counter_if.slave bus
);
  logic count, set_en, sec_co, min_co, hour_co, chime_q, day_carry_q;
  assign count  = !bus.set_mode && bus.tick_1hz;
  assign set_en = bus.set_mode && bus.set_inc;
  // carries only chain while counting, so set-mode wraps never ripple or pulse
  bcd_field_counter #(.MAX_BCD(BCD_59), .RESET_VAL(8'h00)) u_sec (
    .clk, .rst_n,
    .inc(count || (set_en && bus.set_sel == SEL_SEC)),
    .carry_in_en(!bus.set_mode),
    .value(bus.sec), .carry_out(sec_co)
  );
  bcd_field_counter #(.MAX_BCD(BCD_59), .RESET_VAL(RESET_MIN)) u_min (
    .clk, .rst_n,
    .inc(sec_co || (set_en && bus.set_sel == SEL_MIN)),
    .carry_in_en(!bus.set_mode),
    .value(bus.min), .carry_out(min_co)
  );
  bcd_field_counter #(.MAX_BCD(BCD_23), .RESET_VAL(RESET_HOUR)) u_hour (
    .clk, .rst_n,
    .inc(min_co || (set_en && bus.set_sel == SEL_HOUR)),
    .carry_in_en(!bus.set_mode),
    .value(bus.hour), .carry_out(hour_co)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chime_q     <= 1'b0;
      day_carry_q <= 1'b0;
    end else begin
      chime_q     <= min_co;
      day_carry_q <= hour_co;
    end
  assign bus.chime     = chime_q;
  assign bus.day_carry = day_carry_q;
endmodule

// File: tb/tb_clock_time_counter.sv
// tb_clock_time_counter: scoreboard bench; the model tracks seconds-of-day as a plain integer.
module tb_clock_time_counter;
  import clock_pkg::*;
  typedef struct {logic [7:0] h, m, s; logic c, d;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  clock_time_counter_if bus();
  clock_time_counter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, t = 0, dut_chimes = 0, dut_days = 0;
  bit counting = 1'b0;
  function automatic logic [7:0] bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  function automatic bit legal(logic [7:0] v, logic [7:0] mx);
    return v[3:0] <= 4'd9 && v <= mx;
  endfunction
  task automatic check(string name, logic [7:0] h, logic [7:0] m, logic [7:0] s, logic c, logic d);
    n_cmp++;
    if (bus.hour !== h || bus.min !== m || bus.sec !== s || bus.chime !== c || bus.day_carry !== d ||
        !legal(bus.hour, BCD_23) || !legal(bus.min, BCD_59) || !legal(bus.sec, BCD_59)) begin
      n_bad++;
      $display("FAIL %s: got %h:%h:%h chime=%b day=%b, expected %h:%h:%h chime=%b day=%b",
               name, bus.hour, bus.min, bus.sec, bus.chime, bus.day_carry, h, m, s, c, d);
    end
  endtask
  task automatic cmp_int(string name, int got, int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask
  task automatic step(bit tick, bit mode, bit [1:0] sel, bit inc);
    exp_t e;
    int h, m, s;
    bit c, d;
    bus.tick_1hz = tick; bus.set_mode = mode; bus.set_sel = sel; bus.set_inc = inc;
    @(posedge clk);
    h = t / 3600; m = t / 60 % 60; s = t % 60; c = 1'b0; d = 1'b0;
    if (!mode && tick) begin
      t = (t + 1) % 86400;
      c = (t % 3600 == 0);
      d = (t == 0);
    end else if (mode && inc) begin
      if (sel == 2'd0) s = (s + 1) % 60;
      else if (sel == 2'd1) m = (m + 1) % 60;
      else if (sel == 2'd2) h = (h + 1) % 24;
      t = h * 3600 + m * 60 + s;
    end
    e = '{bcd(t / 3600), bcd(t / 60 % 60), bcd(t % 60), c, d};
    q.push_back(e);
    #1;
  endtask
  task automatic set_time(int h, int m, int s);
    int ch, cm, cs;
    ch = t / 3600; cm = t / 60 % 60; cs = t % 60;
    repeat ((h - ch + 24) % 24) step(1'b0, 1'b1, 2'd2, 1'b1);
    repeat ((m - cm + 60) % 60) step(1'b0, 1'b1, 2'd1, 1'b1);
    repeat ((s - cs + 60) % 60) step(1'b0, 1'b1, 2'd0, 1'b1);
    step(1'b0, 1'b0, 2'd3, 1'b0);
  endtask
  task automatic expect_now(string name, logic [7:0] h, logic [7:0] m, logic [7:0] s, logic c, logic d);
    @(negedge clk);
    check(name, h, m, s, c, d);
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (counting && bus.chime) dut_chimes++;
    if (counting && bus.day_carry) dut_days++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("cycle", e.h, e.m, e.s, e.c, e.d);
    end
  end
  initial begin
    bus.tick_1hz = 1'b0; bus.set_mode = 1'b0; bus.set_sel = 2'd3; bus.set_inc = 1'b0;
    #12;
    check("reset_state", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk); #1 rst_n = 1'b1;
    set_time(0, 0, 59); step(1'b1, 1'b0, 2'd3, 1'b0);
    expect_now("sec_carry", 8'h00, 8'h01, 8'h00, 1'b0, 1'b0);
    set_time(0, 9, 59); step(1'b1, 1'b0, 2'd3, 1'b0);
    expect_now("min_tens", 8'h00, 8'h10, 8'h00, 1'b0, 1'b0);
    set_time(9, 59, 59); step(1'b1, 1'b0, 2'd3, 1'b0);
    expect_now("hour_roll", 8'h10, 8'h00, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'd3, 1'b0);
    expect_now("chime_one_cycle", 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
    set_time(23, 59, 59); step(1'b1, 1'b0, 2'd3, 1'b0);
    expect_now("day_roll", 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 2'd3, 1'b0);
    expect_now("day_one_cycle", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    set_time(23, 30, 15); step(1'b0, 1'b1, 2'd2, 1'b1);
    expect_now("set_hour_wrap", 8'h00, 8'h30, 8'h15, 1'b0, 1'b0);
    set_time(0, 59, 15); step(1'b0, 1'b1, 2'd1, 1'b1);
    expect_now("set_min_wrap", 8'h00, 8'h00, 8'h15, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd3, 1'b1);
    expect_now("set_sel_none", 8'h00, 8'h00, 8'h15, 1'b0, 1'b0);
    set_time(12, 0, 0);
    repeat (5) step(1'b1, 1'b1, 2'd3, 1'b0);
    expect_now("freeze", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b1);
    expect_now("tick_priority", 8'h12, 8'h00, 8'h01, 1'b0, 1'b0);
    repeat (400) step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    @(negedge clk); #2;
    bus.tick_1hz = 1'b1; rst_n = 1'b0; #1;
    check("async_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reset_hold", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk); #1;
    bus.tick_1hz = 1'b0; rst_n = 1'b1; t = 0;
    counting = 1'b1;
    repeat (86400) step(1'b1, 1'b0, 2'd3, 1'b0);
    @(negedge clk); #1;
    counting = 1'b0;
    check("exhaustive_end", 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    cmp_int("chime_count", dut_chimes, 24);
    cmp_int("day_count", dut_days, 1);
    @(negedge clk); #1;
    cmp_int("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_time_counter.md
# clock_time_counter

BCD time-of-day counter producing hours (00–23), minutes and seconds for the digital clock. Advances on a one-cycle 1 Hz enable pulse and supports manual setting of a selected field. Sits directly upstream of the 24/12-hour display converter: its `hour` output is the 24-hour BCD hour that stage consumes. It also emits hourly-chime and day-rollover pulses for the alarm and chime logic.

## Interface
- `RESET_HOUR`, default 8'h00: BCD hour loaded on reset; must be a legal value 00–23.
- `RESET_MIN`, default 8'h00: BCD minute loaded on reset; must be 00–59.
- `clk` input 1: system clock; all registers on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tick_1hz` input 1: one-`clk`-cycle enable pulse, once per second.
- `set_mode` input 1: 1 freezes counting and enables manual setting.
- `set_sel` input 2: field to set: 00 seconds, 01 minutes, 10 hours, 11 none.
- `set_inc` input 1: one-cycle pulse; increments the selected field while `set_mode`=1.
- `hour` output 8: BCD hour, [7:4] tens, [3:0] units, 00–23.
- `min` output 8: BCD minute, 00–59.
- `sec` output 8: BCD second, 00–59.
- `chime` output 1: one-cycle pulse on the cycle `min:sec` becomes 00:00 through counting.
- `day_carry` output 1: one-cycle pulse on the 23:59:59→00:00:00 rollover.

## Operation
- Reset, asynchronous on `rst_n`=0:
  - `hour`=RESET_HOUR, `min`=RESET_MIN, `sec`=00.
  - `chime`=0, `day_carry`=0.
- Counting applies when `set_mode`=0 and `tick_1hz`=1.
  - `sec` increments in BCD: units 9→0 carries into tens; 59→00 generates a minute carry.
  - `min` increments only on a minute carry; 59→00 generates an hour carry.
  - `hour` increments only on an hour carry.
    - Units wrap 9→0 with tens+1.
    - 23→00 asserts `day_carry`.
  - `chime` asserts on a counting hour carry, i.e. 59:59→00:00.
- Setting applies when `set_mode`=1.
  - `tick_1hz` is ignored; time is frozen.
  - `set_inc` increments the field chosen by `set_sel` by one in BCD.
    - Sec/min wrap 59→00; hour wraps 23→00.
    - No carry into the next field.
    - `chime`/`day_carry` never assert in set mode.
  - `set_sel`=11: `set_inc` has no effect.
  - Selecting seconds and pulsing `set_inc` is legal; it increments seconds.
- `set_inc` while `set_mode`=0 is ignored.
- All fields always hold legal BCD: nibbles ≤ 9, tens ≤ 5 (≤ 2 for hour), hour ≤ 23.

## Timing
- Registered outputs: a `tick_1hz` sampled at edge N changes `sec`/`min`/`hour` right after edge N. Latency is one cycle, with no extra pipeline.
- `chime` and `day_carry` are registered. They are high for exactly the one cycle in which the rolled-over value (00:00, 00:00:00) is first visible.
- Back-to-back `tick_1hz` on consecutive cycles must each advance by one second. The same holds for back-to-back `set_inc`.
- `set_mode` change takes effect on the same edge it is sampled.
  - A `tick_1hz` coincident with `set_mode` rising is ignored.
  - A `tick_1hz` coincident with `set_mode` falling is counted.
- Reset mid-count: outputs go to reset values immediately, asynchronously. A pending pulse is dropped; no `chime`/`day_carry` is generated.
- Simultaneous `tick_1hz` and `set_inc` with `set_mode`=0: only the tick acts.

## Structure
- Shared package (`clock_pkg`) holds:
  - `BCD_59`=8'h59 and `BCD_23`=8'h23.
  - `SEL_SEC`/`SEL_MIN`/`SEL_HOUR`/`SEL_NONE` 2-bit encodings.
  - Common 8-bit BCD time-field type.
- Natural sub-module: `bcd_field_counter`, instantiated three times.
  - Parameter `MAX_BCD`.
  - Inputs: `inc`, `carry_in_en`.
  - Output: `carry_out` (asserted when the value equals `MAX_BCD` and `inc`=1).
  - Wrap-to-00 handling.
- Top level contains only enable/select gating and the registered `chime`/`day_carry`.

## Test plan
- Reset: assert `rst_n`=0 mid-run with default parameters → outputs 00:00:00, `chime`=0, `day_carry`=0 without waiting for `clk`.
- Seconds carry: start 00:00:59, one `tick_1hz` → 00:01:00, `chime`=0. Start 00:09:59, one tick → 00:10:00.
- Hour/day rollover:
  - Start 09:59:59, tick → 10:00:00 with `chime`=1 for one cycle.
  - Start 23:59:59, tick → 00:00:00 with `chime`=1 and `day_carry`=1 for one cycle.
- Set mode:
  - `set_mode`=1, `set_sel`=10, hour=23, `set_inc` → hour 00, minutes/seconds unchanged, no pulses.
  - `set_sel`=01, min=59, `set_inc` → min 00, hour unchanged.
- Freeze and priority:
  - `set_mode`=1 with 5 ticks → time unchanged.
  - `set_mode`=0 with `tick_1hz` and `set_inc` together at 12:00:00 → 12:00:01.
- Exhaustive run: 86400 ticks from 00:00:00 → returns to 00:00:00.
  - Exactly 24 `chime` pulses and 1 `day_carry`.
  - Every cycle all fields are legal BCD within range.
